// File: rtl/count_arb_pkg.sv
// Shared definitions for the count-slot arbiter: FSM encodings and default sizes.
package count_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 4;

endpackage

// File: rtl/count_slot_arbiter_slot_counter.sv
// slot_counter: CW-bit up-counter shared by all slots. Synchronous clear has
// priority over enable; rst_n clears it asynchronously.
module slot_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;

  // Counter register: clear wins, otherwise advance when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count_slot_arbiter.sv
// count_slot_arbiter: grants timed slots on one shared counter to NREQ
// requesters in round-robin order and pulses done to the slot owner.
// Optional build macro COUNT_SLOT_ARB_HOLD_EN adds a 'hold' input that
// freezes the counter (and stretches the slot) while in RUN.
module count_slot_arbiter
  import count_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef COUNT_SLOT_ARB_HOLD_EN
  input  logic               hold,
`endif
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  // First set request strictly after p, wrapping; returns p when none is set.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx[PW-1:0]]) begin
        w     = idx[PW-1:0];
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   len_q, len_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [PW-1:0]   winner;
  logic [CW-1:0]   win_len;
  logic [CW-1:0]   cnt;
  logic            cnt_clr;
  logic            cnt_en;
  logic            last_w;
  logic            hold_w;

`ifdef COUNT_SLOT_ARB_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign winner  = rr_pick(req, ptr_q);
  assign win_len = len[int'(winner)*CW +: CW];
  // len_q is never zero in RUN, but guard the decrement so it cannot wrap.
  assign last_w  = (len_q != '0) && (cnt == (len_q - 1'b1));

  slot_counter #(
    .CW (CW)
  ) u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt)
  );

  // State, pointer, latched length and the registered grant/done vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      len_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the counter is held clear outside of a continuing RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    gnt_d   = '0;
    done_d  = '0;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          ptr_d = winner;
          len_d = win_len;
          if (win_len != '0) begin
            state_d = ST_RUN;
            gnt_d   = onehot(winner);
          end else begin
            // Zero-length slot: skip RUN and complete immediately.
            state_d = ST_DONE;
            done_d  = onehot(winner);
          end
        end
      end
      ST_RUN: begin
        if (!req[ptr_q]) begin
          // Abandoned: no done pulse, owner keeps lowest priority via ptr.
          state_d = ST_IDLE;
        end else if (hold_w) begin
          gnt_d   = gnt_q;
          cnt_clr = 1'b0;
        end else if (last_w) begin
          state_d = ST_DONE;
          done_d  = onehot(ptr_q);
        end else begin
          gnt_d   = gnt_q;
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  assign count = cnt;

endmodule

// File: tb/tb_count_slot_arbiter.sv
// Directed bench for count_slot_arbiter (NREQ=4, CW=4). Observed vector per
// cycle is {gnt, done, busy, count}; hold scenario only when
// COUNT_SLOT_ARB_HOLD_EN is defined.
module tb_count_slot_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic               clk;
  logic               rst_n;
  logic               hold;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      count;

  int vectors;
  int miscompares;

  count_slot_arbiter #(
    .NREQ (NREQ),
    .CW   (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef COUNT_SLOT_ARB_HOLD_EN
    .hold  (hold),
`endif
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    vectors++;
    if (!$onehot0(gnt) || !$onehot0(done) || ((gnt != 0) && (done != 0))
        || ((gnt == 0) && (count != 0))) begin
      miscompares++;
      $display("FAIL invariant gnt=%b done=%b count=%0d", gnt, done, count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    hold  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    hold  = 1'b0;
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", obs, 13'd0);
    end
    step();
    rst_n = 1'b1;
    $display("reset: gnt=%b done=%b busy=%b count=%0d", gnt, done, busy, count);
  endtask

  task automatic test_single();
    logic [12:0] exp_tbl [5];
    logic [12:0] obs;
    exp_tbl[0] = {4'b0001, 4'b0000, 1'b1, 4'd0};
    exp_tbl[1] = {4'b0001, 4'b0000, 1'b1, 4'd1};
    exp_tbl[2] = {4'b0001, 4'b0000, 1'b1, 4'd2};
    exp_tbl[3] = {4'b0000, 4'b0001, 1'b1, 4'd0};
    exp_tbl[4] = {4'b0000, 4'b0000, 1'b0, 4'd0};
    len = 16'h0003;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      obs = {gnt, done, busy, count};
      vectors++;
      if (obs !== exp_tbl[i]) begin
        miscompares++;
        $display("FAIL single cyc%0d got=%h exp=%h", i, obs, exp_tbl[i]);
      end
      $display("single cyc%0d: gnt=%b done=%b busy=%b count=%0d", i, gnt, done, busy, count);
      if (i == 3) req = '0;
    end
  endtask

  task automatic test_round_robin();
    int          order [5];
    logic [3:0]  oh;
    logic [12:0] exp_v;
    logic [12:0] obs;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    len = 16'h2222;
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      oh = 4'b0001 << order[s];
      for (int c = 0; c < 4; c++) begin
        step();
        if (c < 2)       exp_v = {oh, 4'b0000, 1'b1, 4'(c)};
        else if (c == 2) exp_v = {4'b0000, oh, 1'b1, 4'd0};
        else             exp_v = 13'd0;
        obs = {gnt, done, busy, count};
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL rr slot%0d cyc%0d got=%h exp=%h", s, c, obs, exp_v);
        end
        if (s == 4 && c == 2) req = '0;
      end
      $display("rr slot%0d: expected winner %0d", s, order[s]);
    end
  endtask

  task automatic test_zero_len();
    logic [12:0] obs;
    len = 16'h0000;
    req = 4'b0100;
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== {4'b0000, 4'b0100, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL zero_len done got=%h exp=%h", obs, {4'b0000, 4'b0100, 1'b1, 4'd0});
    end
    req = '0;
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL zero_len idle got=%h exp=%h", obs, 13'd0);
    end
    $display("zero_len: done pulse then idle");
  endtask

  task automatic test_abandon();
    logic [12:0] obs;
    logic [12:0] exp_v;
    len = 16'h0053;
    req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      exp_v = {4'b0010, 4'b0000, 1'b1, 4'(c)};
      obs = {gnt, done, busy, count};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL abandon run%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    req = 4'b0001;
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL abandon drop got=%h exp=%h", obs, 13'd0);
    end
    req = 4'b0011;
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== {4'b0001, 4'b0000, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL abandon next_gnt got=%h exp=%h", obs, {4'b0001, 4'b0000, 1'b1, 4'd0});
    end
    req = '0;
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL abandon second got=%h exp=%h", obs, 13'd0);
    end
    $display("abandon: req1 dropped at count 2, requester 0 granted next");
  endtask

  task automatic test_reset_mid_slot();
    logic [12:0] obs;
    logic [12:0] exp_v;
    do_reset();
    len = 16'h000F;
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step();
      exp_v = {4'b0001, 4'b0000, 1'b1, 4'(c)};
      obs = {gnt, done, busy, count};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL midrst run%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL midrst async_clear got=%h exp=%h", obs, 13'd0);
    end
    req = '0;
    step();
    rst_n = 1'b1;
    len = 16'h1000;
    req = 4'b1000;
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== {4'b1000, 4'b0000, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL midrst req3_gnt got=%h exp=%h", obs, {4'b1000, 4'b0000, 1'b1, 4'd0});
    end
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== {4'b0000, 4'b1000, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL midrst req3_done got=%h exp=%h", obs, {4'b0000, 4'b1000, 1'b1, 4'd0});
    end
    req = '0;
    step();
    $display("reset_mid_slot: cleared at count 7, requester 3 served after release");
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_tbl [6];
    logic [12:0] obs;
    exp_tbl[0] = {4'b0001, 4'b0000, 1'b1, 4'd0};
    exp_tbl[1] = {4'b0000, 4'b0001, 1'b1, 4'd0};
    exp_tbl[2] = 13'd0;
    exp_tbl[3] = {4'b1000, 4'b0000, 1'b1, 4'd0};
    exp_tbl[4] = {4'b0000, 4'b1000, 1'b1, 4'd0};
    exp_tbl[5] = 13'd0;
    do_reset();
    len = 16'h1001;
    req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      step();
      obs = {gnt, done, busy, count};
      vectors++;
      if (obs !== exp_tbl[i]) begin
        miscompares++;
        $display("FAIL b2b cyc%0d got=%h exp=%h", i, obs, exp_tbl[i]);
      end
      if (i == 4) req = '0;
    end
    $display("back_to_back: requester 0 then 3 after reset");
  endtask

`ifdef COUNT_SLOT_ARB_HOLD_EN
  task automatic test_hold();
    logic [3:0]  cnt_tbl [7];
    logic [12:0] obs;
    logic [12:0] exp_v;
    cnt_tbl = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
    do_reset();
    len  = 16'h0004;
    req  = 4'b0001;
    hold = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      exp_v = {4'b0001, 4'b0000, 1'b1, cnt_tbl[i]};
      obs = {gnt, done, busy, count};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL hold cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 1) hold = 1'b1;
      if (i == 4) hold = 1'b0;
    end
    step();
    obs = {gnt, done, busy, count};
    vectors++;
    if (obs !== {4'b0000, 4'b0001, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL hold done got=%h exp=%h", obs, {4'b0000, 4'b0001, 1'b1, 4'd0});
    end
    req = '0;
    step();
    $display("hold: slot stretched to 7 cycles");
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    req         = '0;
    len         = '0;
    hold        = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_abandon();
    test_reset_mid_slot();
    test_back_to_back();
`ifdef COUNT_SLOT_ARB_HOLD_EN
    test_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
